divisor_mantiza: RTL
====================

Name: divisor_mantiza

Overview:
Iterative mantissa divider for the team's 8-bit-mantissa float format, with hidden leading 1; it is the inverse operation of the mantissa multiplier. It computes (1.m1)/(1.m2) by restoring division, one quotient bit per clock. It returns a normalized 8-bit mantissa plus an exponent-correction flag, which tells the exponent path to decrement by 1. It sits in the FP divide datapath beside the exponent subtractor and uses a start/valid handshake.

Parameters:
N_MANTIZA, 8, stored mantissa width in bits; quotient width and iteration count are N_MANTIZA+2.

Ports:
i_clock  input  1  single clock, rising edge
i_reset_n  input  1  asynchronous, active-low reset
i_start  input  1  request; sampled only while o_ready=1
i_mantiza_1  input  N_MANTIZA  dividend mantissa, hidden 1 not included
i_mantiza_2  input  N_MANTIZA  divisor mantissa, hidden 1 not included
o_ready  output  1  high only in IDLE
o_valid  output  1  one-cycle result strobe
o_mantiza  output  N_MANTIZA  normalized quotient mantissa, hidden 1 stripped
o_aviso_exponente  output  1  1 = quotient was <1 and was shifted left; exponent must be decremented

Behaviour:
- Reset (async, i_reset_n=0): state=IDLE, o_valid=0, o_mantiza=0, o_aviso_exponente=0, o_ready=1, internal registers cleared. Reset mid-operation aborts the operation with no o_valid.
- Arithmetic: D={1,i_mantiza_1}, V={1,i_mantiza_2}, both 9 bits. Q=floor(D*2^9/V), 10 bits, range 256..1022. V is never 0, so divide-by-zero cannot occur.
- Truncation only; no rounding.
- Normalization when Q[9]=1: o_mantiza=Q[8:1], aviso=0.
- Normalization when Q[9]=0: o_mantiza=Q[7:0], aviso=1.
- FSM IDLE: o_ready=1. On i_start=1 at edge k, latch D and V, clear remainder and bit counter, go to CALC.
- FSM CALC: edges k+1..k+10, one restoring step each, MSB first.
  - Step: R'={R,next numerator bit}; if R'>=V then R=R'-V, q=1; else R=R', q=0.
  - Width: partial remainder is 10 bits; compare and subtract are 10 bits.
  - At edge k+10, register o_mantiza and aviso, then go to DONE.
- FSM DONE: o_valid=1 for exactly this cycle; next edge goes to IDLE.
- Output hold: o_mantiza and aviso keep their value until the next result is registered.
- Latency: o_valid is high in the cycle after edge k+10. Next start is accepted at edge k+12 at earliest.
- i_start while o_ready=0: ignored, no queuing.
- Input changes during CALC have no effect because operands are latched.
- i_start held high continuously: one operation every 12 cycles.

Optional Feature:
Macro DIVISOR_MANTIZA_INEXACTO_EN.
- Defined: adds output port o_inexacto (1 bit). It is registered with o_mantiza and is 1 when the final remainder is nonzero OR a 1 was dropped by normalization (Q[0] when Q[9]=1). Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package divisor_mantiza_pkg:
  - state typedef/encoding for IDLE/CALC/DONE;
  - localparams for quotient width (N+2), remainder width, and counter width (clog2 of N+2).
- Sub-module etapa_resta_restauradora: combinational single restoring step.
  - Inputs: partial remainder, next numerator bit, divisor.
  - Outputs: next remainder, quotient bit.
- Top holds the FSM, counter, shift registers and normalization.

Test Plan:
- Reset mid-CALC: start m1=0x80, m2=0x00; assert i_reset_n=0 at cycle 5 -> o_valid never pulses, outputs 0, o_ready=1 right after reset.
- 1.0/1.0: m1=0x00, m2=0x00 -> Q=512, o_mantiza=0x00, aviso=0; o_valid exactly one cycle after edge k+10; o_ready low from k+1 through k+11.
- 1.5/1.0: m1=0x80, m2=0x00 -> Q=768, o_mantiza=0x80, aviso=0, inexacto=0.
- 1.0/1.5: m1=0x00, m2=0x80 -> Q=341, o_mantiza=0x55, aviso=1, inexacto=1.
- Extremes:
  - m1=0xFF, m2=0x00 -> o_mantiza=0xFF, aviso=0, inexacto=0 (Q=1022).
  - m1=0x00, m2=0xFF -> o_mantiza=0x00, aviso=1, inexacto=1 (Q=256).
- Handshake:
  - i_start held high with inputs changing every cycle -> exactly one result per 12 cycles, each matching the operands latched at its accept edge.
  - Random 1000 pairs checked against the floor formula.

Source files
------------

// File: rtl/divisor_mantiza_pkg.sv
// rtl/divisor_mantiza_pkg.sv - shared widths and FSM encoding for the mantissa divider
package divisor_mantiza_pkg;

    localparam int N_MANTIZA_PKG  = 8;
    localparam int ANCHO_COCIENTE = N_MANTIZA_PKG + 2;
    localparam int ANCHO_RESTO    = N_MANTIZA_PKG + 2;
    localparam int ANCHO_CUENTA   = $clog2(ANCHO_COCIENTE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } estado_t;

endpackage

// File: rtl/etapa_resta_restauradora.sv
// rtl/etapa_resta_restauradora.sv - one combinational restoring-division step
module etapa_resta_restauradora #(
    parameter int ANCHO = 10
) (
    input  logic [ANCHO-2:0] i_resto,
    input  logic             i_bit,
    input  logic [ANCHO-2:0] i_divisor,
    output logic [ANCHO-2:0] o_resto,
    output logic             o_bit_cociente
);

    logic [ANCHO-1:0] w_desplazado;
    logic [ANCHO-2:0] w_resta;

    // The incoming remainder is always below the divisor, so the shifted value
    // needs one extra bit for the compare, while the difference (again below
    // the divisor) fits in the narrower width.
    always_comb begin
        w_desplazado   = {i_resto, i_bit};
        w_resta        = w_desplazado[ANCHO-2:0] - i_divisor;
        o_bit_cociente = (w_desplazado >= {1'b0, i_divisor});
        o_resto        = o_bit_cociente ? w_resta : w_desplazado[ANCHO-2:0];
    end

endmodule

// File: rtl/divisor_mantiza.sv
// rtl/divisor_mantiza.sv - iterative (1.m1)/(1.m2) mantissa divider; option DIVISOR_MANTIZA_INEXACTO_EN adds o_inexacto
module divisor_mantiza
    import divisor_mantiza_pkg::*;
#(
    parameter int N_MANTIZA = N_MANTIZA_PKG
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_start,
    input  logic [N_MANTIZA-1:0] i_mantiza_1,
    input  logic [N_MANTIZA-1:0] i_mantiza_2,
    output logic                 o_ready,
    output logic                 o_valid,
    output logic [N_MANTIZA-1:0] o_mantiza,
    output logic                 o_aviso_exponente
`ifdef DIVISOR_MANTIZA_INEXACTO_EN
    ,
    output logic                 o_inexacto
`endif
);

    localparam logic [ANCHO_CUENTA-1:0] ULTIMA_CUENTA = ANCHO_CUENTA'(ANCHO_COCIENTE - 1);

    estado_t                    r_estado;
    estado_t                    w_estado_sig;
    logic [N_MANTIZA-1:0]       r_dividendo_alto;
    logic [N_MANTIZA:0]         r_divisor;
    logic [ANCHO_RESTO-2:0]     r_resto;
    logic [ANCHO_RESTO-1:0]     r_numerador;
    logic [ANCHO_COCIENTE-2:0]  r_cociente;
    logic [ANCHO_CUENTA-1:0]    r_cuenta;

    logic [ANCHO_RESTO-2:0]     w_resto_actual;
    logic [ANCHO_RESTO-2:0]     w_resto_sig;
    logic                       w_bit_q;
    logic [ANCHO_COCIENTE-1:0]  w_cociente;
    logic                       w_ultima;

    // The leading N numerator bits are below the divisor, so their all-zero
    // quotient steps are folded into the first step by seeding the remainder
    // with them; the remaining N+2 steps each emit one real quotient bit.
    always_comb begin
        w_resto_actual = (r_cuenta == '0) ? {1'b0, r_dividendo_alto} : r_resto;
        w_cociente     = {r_cociente, w_bit_q};
        w_ultima       = (r_cuenta == ULTIMA_CUENTA);
    end

    etapa_resta_restauradora #(
        .ANCHO (ANCHO_RESTO)
    ) u_etapa (
        .i_resto        (w_resto_actual),
        .i_bit          (r_numerador[ANCHO_RESTO-1]),
        .i_divisor      (r_divisor),
        .o_resto        (w_resto_sig),
        .o_bit_cociente (w_bit_q)
    );

    // State register
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_estado <= IDLE;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_estado_sig = r_estado;
        o_ready      = 1'b0;
        o_valid      = 1'b0;
        case (r_estado)
            IDLE: begin
                o_ready = 1'b1;
                if (i_start) begin
                    w_estado_sig = CALC;
                end
            end
            CALC: begin
                if (w_ultima) begin
                    w_estado_sig = DONE;
                end
            end
            DONE: begin
                o_valid      = 1'b1;
                w_estado_sig = IDLE;
            end
            default: begin
                w_estado_sig = IDLE;
            end
        endcase
    end

    // Operand latch, iteration registers and normalized result
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_dividendo_alto  <= '0;
            r_divisor         <= '0;
            r_resto           <= '0;
            r_numerador       <= '0;
            r_cociente        <= '0;
            r_cuenta          <= '0;
            o_mantiza         <= '0;
            o_aviso_exponente <= 1'b0;
`ifdef DIVISOR_MANTIZA_INEXACTO_EN
            o_inexacto        <= 1'b0;
`endif
        end else begin
            case (r_estado)
                IDLE: begin
                    if (i_start) begin
                        r_dividendo_alto <= {1'b1, i_mantiza_1[N_MANTIZA-1:1]};
                        r_divisor        <= {1'b1, i_mantiza_2};
                        r_numerador      <= {i_mantiza_1[0], {(ANCHO_RESTO-1){1'b0}}};
                        r_resto          <= '0;
                        r_cociente       <= '0;
                        r_cuenta         <= '0;
                    end
                end
                CALC: begin
                    r_resto     <= w_resto_sig;
                    r_cociente  <= w_cociente[ANCHO_COCIENTE-2:0];
                    r_numerador <= r_numerador << 1;
                    r_cuenta    <= r_cuenta + 1'b1;
                    if (w_ultima) begin
                        if (w_cociente[ANCHO_COCIENTE-1]) begin
                            o_mantiza         <= w_cociente[ANCHO_COCIENTE-2:1];
                            o_aviso_exponente <= 1'b0;
                        end else begin
                            o_mantiza         <= w_cociente[ANCHO_COCIENTE-3:0];
                            o_aviso_exponente <= 1'b1;
                        end
`ifdef DIVISOR_MANTIZA_INEXACTO_EN
                        o_inexacto <= (w_resto_sig != '0) ||
                                      (w_cociente[ANCHO_COCIENTE-1] && w_cociente[0]);
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
